// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller sharing one external BCD decoder.
// Display values load through a valid/ready port and commit only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int NDIG          = 4,
  parameter int PRESCALE      = 50000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] din,
  input  logic              blank_lz,
  output logic [3:0]        dec_bcd,
  input  logic [6:0]        dec_seg,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NDIG > 2) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] LAST_I = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_OFF = AN_ACTIVE_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     presc, presc_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [4*NDIG-1:0] active, shadow;
  logic              pending;

  logic              transfer, slot_end, frame_end, lit;
  logic [3:0]        cur_digit;
  logic              lz_all, blank;
  logic [NDIG-1:0]   onehot;
  logic [6:0]        seg_nx;
  logic [NDIG-1:0]   an_nx;

  assign transfer  = load && load_ready;
  assign slot_end  = (state == SCAN) && (presc == LAST_P);
  assign frame_end = slot_end && (idx == LAST_I);
  // Next cycle is slot cycle 0 whenever this slot ends, so the output register goes dark.
  assign lit       = (state == SCAN) && !slot_end;

  always_comb begin
    cur_digit = 4'd0;
    onehot    = '0;
    lz_all    = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = active[4*i +: 4];
        onehot[i] = 1'b1;
      end
      if ((IW'(i) >= idx) && (active[4*i +: 4] != 4'd0)) lz_all = 1'b0;
    end
  end

  assign dec_bcd = cur_digit;
  assign blank   = (cur_digit > 4'd9) || (blank_lz && (idx != '0) && lz_all);

  always_comb begin
    seg_nx = (lit && !blank) ? dec_seg : 7'd0;
    if (!lit)               an_nx = AN_OFF;
    else if (AN_ACTIVE_LOW) an_nx = ~onehot;
    else                    an_nx = onehot;
  end

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        presc_nx = '0;
        idx_nx   = '0;
        if (transfer) state_nx = SCAN;
      end
      SCAN: begin
        if (slot_end) begin
          presc_nx = '0;
          idx_nx   = (idx == LAST_I) ? '0 : idx + 1'b1;
        end else begin
          presc_nx = presc + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      presc <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      idx   <= idx_nx;
    end
  end

  // Commit happens on the wrap edge so the whole new frame uses the new digits;
  // load_ready stays low through the frame_done cycle and reopens after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
    end else if (state == IDLE) begin
      if (transfer) active <= din;
    end else if (transfer) begin
      shadow     <= din;
      pending    <= 1'b1;
      load_ready <= 1'b0;
    end else if (pending) begin
      if (frame_end) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end else begin
      load_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'd0;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nx;
      an         <= an_nx;
      frame_done <= frame_end;
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for an NDIG-digit common-anode/cathode 7-segment display.
- Shares a single external BCDto7seg decoder across all digits: presents one BCD digit per scan slot on dec_bcd, takes back the decoded pattern on dec_seg, and drives segment and anode lines.
- Accepts new display values through a valid/ready load port and commits them only at frame boundaries, so frames never tear.

Parameters:
- NDIG, 4, number of digits scanned; must be 2..8.
- PRESCALE, 50000, clk cycles per digit slot; must be at least 4.
- AN_ACTIVE_LOW, 1, 1 = anode enables active-low, 0 = active-high.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  load request; din is valid while high.
- load_ready  out  1  controller can accept din this cycle.
- din  in  4*NDIG  BCD digits; digit 0 (least significant) is din[3:0].
- blank_lz  in  1  enable leading-zero blanking; sampled every slot.
- dec_bcd  out  4  BCD value to the shared decoder (combinational from the current index and active register).
- dec_seg  in  7  decoder output, combinational from dec_bcd, active-high segments.
- seg  out  7  registered segment drive, active-high.
- an  out  NDIG  registered anode enables, polarity set by AN_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset values (asynchronous):
  - seg=0, an=all inactive, load_ready=1, frame_done=0.
  - Prescaler=0, index=0, active and shadow registers=0, pending=0.
  - State=IDLE.
- States:
  - IDLE: display dark, prescaler held at 0. The first load handshake commits din straight to the active register and moves to SCAN on the next cycle with index=0.
  - SCAN: free-running scan. There is no return to IDLE except by reset.
- Prescaler:
  - Counts 0..PRESCALE-1 in SCAN.
  - At terminal count it wraps to 0 and index advances. Index wraps from NDIG-1 to 0.
  - frame_done pulses in the same cycle that index wraps to 0.
- Slot timing, where cycle 0 is the first cycle of a slot:
  - Cycle 0: an is all inactive and seg=0 (ghost-blanking interval).
  - Cycles 1..PRESCALE-1: seg = registered dec_seg for the current index; an has exactly one bit active, bit[index].
  - Latency from index change to valid seg/an: 1 cycle.
- Forced blanking (seg=0, anode still enabled):
  - The digit value is greater than 9 (values 10-15). Decoder output for these values is ignored.
  - blank_lz=1, index is not 0, and every digit from NDIG-1 down to index is 0. Digit 0 is never blanked by this rule.
- Load handshake:
  - A transfer occurs when load && load_ready on a clk edge.
  - In SCAN, din goes into the shadow register, pending is set and load_ready drops.
  - At the next frame boundary (the cycle frame_done pulses), shadow is copied to active, pending clears, and load_ready returns to 1 on the following cycle.
  - load while load_ready=0 is ignored; no data is captured.
- Simultaneous events: a load transfer and a frame boundary in the same cycle. The new data is captured into shadow and is not committed until the next boundary.
- Reset asserted mid-frame: all outputs return to reset values immediately and any pending shadow data is discarded.
- Width: prescaler is clog2(PRESCALE) bits; index is clog2(NDIG) bits with a minimum of 1.

Test Plan (NDIG=4, PRESCALE=4, AN_ACTIVE_LOW=1, bench instantiates BCDto7seg as the decoder):
- Reset, then no load for 20 cycles -> an=4'b1111, seg=0, load_ready=1 throughout.
- Load din=16'h1234 with blank_lz=0 -> scan order digits 4,3,2,1 on an=1110,1101,1011,0111. Each slot shows one blank cycle then 3 cycles of the decoder pattern for that digit. frame_done pulses every 16 cycles.
- During a frame, load 16'h5678 -> load_ready=0 until the boundary. The old digits finish the current frame; the next frame shows 8,7,6,5. A second load during pending is ignored.
- Load 16'h0042 with blank_lz=1 -> digits 3 and 2 give seg=0 with their anode active; digits 1 and 0 show 4 and 2. Load 16'h0000 -> only digit 0 shows "0".
- Load 16'h00A9 -> digit 1 (value A) forces seg=0; digit 0 shows 9.
- Assert rst_n=0 mid-slot while pending=1 -> immediate seg=0, an=1111, load_ready=1. After release the controller is in IDLE and the old shadow value never appears.
